lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 112 +++++++++++
 1 files changed

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit bridging a request/response handshake to a
// synchronous word memory, with lane steering, store strobes and load extension.
module lsu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_in_wen,
  input  logic [1:0]  i_in_size,
  input  logic        i_in_unsigned,
  input  logic [31:0] i_in_addr,
  input  logic [31:0] i_in_wdata,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_rdata,
  output logic        o_out_err,
  output logic        o_mem_en,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic [31:0] i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t      r_state;
  logic        r_in_ready, r_out_valid, r_out_err, r_mem_en, r_mem_wr;
  logic        r_wen, r_uns;
  logic [1:0]  r_size, r_off;
  logic [31:0] r_out_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        w_err;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata, w_shift, w_ext;
  assign w_err = (i_in_size == 2'd3) || (i_in_size == 2'd1 && i_in_addr[0]) ||
                 (i_in_size == 2'd2 && i_in_addr[1:0] != 2'd0);
  assign w_strb = (i_in_size == 2'd0) ? 4'b0001 << i_in_addr[1:0] :
                  (i_in_size == 2'd1) ? 4'b0011 << i_in_addr[1:0] : 4'hF;
  assign w_wdata = (i_in_size == 2'd0) ? {4{i_in_wdata[7:0]}} :
                   (i_in_size == 2'd1) ? {2{i_in_wdata[15:0]}} : i_in_wdata;
  // read word arrives one cycle after the enable, i.e. while in WAIT
  assign w_shift = i_mem_rdata >> {r_off, 3'b000};
  assign w_ext = (r_size == 2'd0) ? {{24{~r_uns & w_shift[7]}}, w_shift[7:0]} :
                 (r_size == 2'd1) ? {{16{~r_uns & w_shift[15]}}, w_shift[15:0]} : w_shift;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_rdata <= '0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wstrb <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wen       <= 1'b0;
      r_uns       <= 1'b0;
      r_size      <= '0;
      r_off       <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_in_valid) begin
          r_wen      <= i_in_wen;
          r_uns      <= i_in_unsigned;
          r_size     <= i_in_size;
          r_off      <= i_in_addr[1:0];
          r_in_ready <= 1'b0;
          if (w_err) begin
            r_state     <= RESP;
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b1;
            r_out_rdata <= '0;
          end else begin
            r_state     <= ACCESS;
            r_mem_en    <= 1'b1;
            r_mem_wr    <= i_in_wen;
            r_mem_wstrb <= i_in_wen ? w_strb : 4'h0;
            r_mem_addr  <= {i_in_addr[31:2], 2'b00};
            r_mem_wdata <= w_wdata;
          end
        end
        ACCESS: begin
          r_state     <= WAIT;
          r_mem_en    <= 1'b0;
          r_mem_wr    <= 1'b0;
          r_mem_wstrb <= '0;
        end
        WAIT: begin
          r_state     <= RESP;
          r_out_valid <= 1'b1;
          r_out_err   <= 1'b0;
          r_out_rdata <= r_wen ? 32'd0 : w_ext;
        end
        RESP: if (i_out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_rdata = r_out_rdata;
  assign o_out_err   = r_out_err;
  assign o_mem_en    = r_mem_en;
  assign o_mem_wr    = r_mem_wr;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;
endmodule
